// File: rtl/set_pkg.sv
// set_pkg: shared widths, job record and FSM state for the SET dispatcher.
// Contents: COORD_W/RADIUS_W/CAND_W widths, CAND_TIMEOUT, job_t, state_t.
package set_pkg;

   localparam int COORD_W   = 4;
   localparam int CENTRAL_W = 2 * COORD_W;
   localparam int RADIUS_W  = 4;
   localparam int CAND_W    = 8;
   localparam int TAG_W_MAX = 16;

   localparam logic [CAND_W-1:0] CAND_TIMEOUT = 8'hFF;

   // Tag field is sized for the widest supported tag; the
   // dispatcher zero-extends its TAG_W counter into it.
   typedef struct packed {
      logic [CENTRAL_W-1:0] central;
      logic [RADIUS_W-1:0]  radius;
      logic [TAG_W_MAX-1:0] tag;
   } job_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/set_job_fifo.sv
// set_job_fifo: synchronous job queue, FIFO_DEPTH entries (power of 2).
// Ports: clk, rst (sync, high), push/push_job, pop, head, full, empty.
module set_job_fifo
   import set_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  job_t push_job,
   input  logic pop,
   output job_t head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   job_t mem [FIFO_DEPTH];

   // One extra pointer bit tells full from empty.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= push_job;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/set_dispatcher.sv
// set_dispatcher: queues (central, radius) jobs and runs them one at a
// time on the SET engine, returning tagged candidate counts in order.
// Ports: clk, rst (sync, high); req_* job input (valid/ready);
// set_* engine handshake (en pulse, busy, valid, candidate);
// res_* tagged result output (valid/ready); idle.
// Option macro SET_TIMEOUT_EN: WAIT timeout after TIMEOUT_CYC cycles,
// result 8'hFF, sticky timeout_err output. TAG_W must be <= 16.
module set_dispatcher
   import set_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TAG_W       = 6,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [CENTRAL_W-1:0] req_central,
   input  logic [RADIUS_W-1:0]  req_radius,
   output logic                 set_en,
   output logic [CENTRAL_W-1:0] set_central,
   output logic [RADIUS_W-1:0]  set_radius,
   input  logic                 set_busy,
   input  logic                 set_valid,
   input  logic [CAND_W-1:0]    set_candidate,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [CAND_W-1:0]    res_candidate,
   output logic [TAG_W-1:0]     res_tag,
   output logic                 idle
`ifdef SET_TIMEOUT_EN
   ,
   output logic                 timeout_err
`endif
);

   state_t           state;
   logic [TAG_W-1:0] tag_cnt;
   logic [TAG_W-1:0] cur_tag;
   job_t             push_job;
   job_t             head;
   logic             full;
   logic             empty;
   logic             push;
   logic             issue;

   assign req_ready = !full && !rst;
   assign push      = req_valid && req_ready;
   assign issue     = (state == ST_IDLE) && !empty && !set_busy;
   assign idle      = empty && (state == ST_IDLE);

   always_comb begin
      push_job         = '0;
      push_job.central = req_central;
      push_job.radius  = req_radius;
      push_job.tag     = TAG_W_MAX'(tag_cnt);
   end

   set_job_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_job(push_job),
      .pop     (issue),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   // Upper tag bits are always zero; only TAG_W of them are consumed.
   logic unused_head_tag;
   assign unused_head_tag = ^head.tag;

`ifdef SET_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] wait_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         set_en        <= 1'b0;
         set_central   <= '0;
         set_radius    <= '0;
         res_valid     <= 1'b0;
         res_candidate <= '0;
         res_tag       <= '0;
         cur_tag       <= '0;
         tag_cnt       <= '0;
`ifdef SET_TIMEOUT_EN
         wait_cnt      <= '0;
         timeout_err   <= 1'b0;
`endif
      end else begin
         set_en <= 1'b0;
         if (push)
            tag_cnt <= tag_cnt + TAG_W'(1);
         unique case (state)
            ST_IDLE: begin
               if (issue) begin
                  set_en      <= 1'b1;
                  set_central <= head.central;
                  set_radius  <= head.radius;
                  cur_tag     <= head.tag[TAG_W-1:0];
`ifdef SET_TIMEOUT_EN
                  wait_cnt    <= '0;
`endif
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (set_valid) begin
                  res_candidate <= set_candidate;
                  res_tag       <= cur_tag;
                  res_valid     <= 1'b1;
                  state         <= ST_HOLD;
               end
`ifdef SET_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  res_candidate <= CAND_TIMEOUT;
                  res_tag       <= cur_tag;
                  res_valid     <= 1'b1;
                  timeout_err   <= 1'b1;
                  state         <= ST_HOLD;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
               end
`endif
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_dispatcher.sv
// tb_set_dispatcher: randomized scoreboard bench for set_dispatcher.
// A SET engine model answers jobs; a monitor checks results in order.
module tb_set_dispatcher;

   localparam int TAG_W   = 6;
   localparam int TAG_MOD = 1 << TAG_W;
   localparam int TO_CYC  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [7:0]       req_central;
   logic [3:0]       req_radius;
   logic             set_en;
   logic [7:0]       set_central;
   logic [3:0]       set_radius;
   logic             set_busy;
   logic             set_valid;
   logic [7:0]       set_candidate;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_candidate;
   logic [TAG_W-1:0] res_tag;
   logic             idle;
`ifdef SET_TIMEOUT_EN
   logic             timeout_err;
`endif

   always #5 clk = ~clk;

   set_dispatcher #(
      .FIFO_DEPTH (4),
      .TAG_W      (TAG_W),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_central  (req_central),
      .req_radius   (req_radius),
      .set_en       (set_en),
      .set_central  (set_central),
      .set_radius   (set_radius),
      .set_busy     (set_busy),
      .set_valid    (set_valid),
      .set_candidate(set_candidate),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_candidate(res_candidate),
      .res_tag      (res_tag),
      .idle         (idle)
`ifdef SET_TIMEOUT_EN
      ,
      .timeout_err  (timeout_err)
`endif
   );

   typedef struct {
      logic [7:0] c;
      logic [3:0] r;
      int         tag;
   } job_rec_t;

   typedef struct {
      logic [7:0] cand;
      int         tag;
   } res_rec_t;

   job_rec_t job_q[$];
   res_rec_t exp_q[$];

   int errors = 0;
   int checks = 0;
   int tag_model = 0;
   int cyc = 0;
   logic rst_q = 1'b1;

   int fix_lat = -1;
   int fix_cand = -1;
   bit no_resp = 1'b0;
   bit hold_busy = 1'b0;
   int rdy_mode = 0;
   int res_seen = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/empty expected event", nm);
   endtask

   function automatic logic [7:0] rnd_central();
      logic [3:0] x;
      logic [3:0] y;
      x = 4'($urandom_range(1, 8));
      y = 4'($urandom_range(1, 8));
      return {x, y};
   endfunction

   // SET engine model: busy from en until its result strobe.
   initial begin : set_model
      bit         pending;
      int         cnt;
      logic [7:0] cand;
      bit         prev_en;
      job_rec_t   j;
      pending = 1'b0;
      cnt = 0;
      cand = '0;
      prev_en = 1'b0;
      set_valid = 1'b0;
      set_busy = 1'b0;
      set_candidate = '0;
      forever begin
         @(posedge clk);
         #1;
         set_valid = 1'b0;
         set_candidate = 8'($urandom);
         if (set_en) begin
            check("en_one_cycle", {31'd0, prev_en}, 0);
            if (job_q.size() == 0) begin
               fail("spurious_set_en");
            end else begin
               j = job_q.pop_front();
               check("set_central", set_central, j.c);
               check("set_radius", set_radius, j.r);
               cand = (fix_cand >= 0) ? 8'(fix_cand)
                                      : 8'($urandom_range(0, 64));
               if (no_resp) begin
                  exp_q.push_back('{8'hFF, j.tag});
               end else begin
                  exp_q.push_back('{cand, j.tag});
                  pending = 1'b1;
                  cnt = (fix_lat > 0) ? fix_lat : $urandom_range(1, 12);
               end
            end
         end else if (pending) begin
            cnt--;
            if (cnt <= 0) begin
               set_valid = 1'b1;
               set_candidate = cand;
               pending = 1'b0;
            end
         end
         prev_en = set_en;
         set_busy = pending || hold_busy;
      end
   end

   // Result monitor: in-order scoreboard plus HOLD stability.
   initial begin : monitor
      bit               prev_hold;
      logic [7:0]       pc;
      logic [TAG_W-1:0] pt;
      res_rec_t         e;
      prev_hold = 1'b0;
      pc = '0;
      pt = '0;
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_q) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("hold_valid", {31'd0, res_valid}, 1);
               check("hold_cand", res_candidate, pc);
               check("hold_tag", res_tag, pt);
               check("hold_no_en", {31'd0, set_en}, 0);
            end
            if (res_valid)
               res_seen++;
            if (rdy_mode == 1)
               res_ready = 1'b1;
            else if (rdy_mode == 2)
               res_ready = 1'b0;
            else
               res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_result");
               end else begin
                  e = exp_q.pop_front();
                  check("res_cand", res_candidate, e.cand);
                  check("res_tag", res_tag, e.tag);
               end
            end
            prev_hold = res_valid && !res_ready;
            pc = res_candidate;
            pt = res_tag;
         end
      end
   end

   task automatic push_job(input logic [7:0] c, input logic [3:0] r);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_central = c;
      req_radius = r;
      while (!req_ready && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         fail("push_accept");
      end else begin
         job_q.push_back('{c, r, tag_model});
         tag_model = (tag_model + 1) % TAG_MOD;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < bound) begin
         @(posedge clk);
         #1;
         n++;
         done = (job_q.size() == 0) && (exp_q.size() == 0) &&
                idle && !res_valid;
      end
      check("drain", {31'd0, done}, 1);
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", {31'd0, req_ready}, 0);
      check("rst_set_en", {31'd0, set_en}, 0);
      check("rst_set_central", set_central, 0);
      check("rst_set_radius", set_radius, 0);
      check("rst_res_valid", {31'd0, res_valid}, 0);
      check("rst_res_cand", res_candidate, 0);
      check("rst_res_tag", res_tag, 0);
      check("rst_idle", {31'd0, idle}, 1);
   endtask

   initial begin : main
      int         acc;
      int         n;
      int         base;
      logic [7:0] c5;
      logic [3:0] r5;
`ifdef SET_TIMEOUT_EN
      int         en_cyc;
`endif
      rst = 1'b1;
      req_valid = 1'b0;
      req_central = '0;
      req_radius = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 1);

      // Single job, fixed latency and candidate; minimum issue latency.
      fix_lat = 10;
      fix_cand = 29;
      push_job(8'h44, 4'd3);
      check("issue_lat_n", {31'd0, set_en}, 0);
      @(posedge clk);
      #1;
      check("issue_lat_n1", {31'd0, set_en}, 1);
      wait_drain(200);
      fix_lat = -1;
      fix_cand = -1;

      // Fill while SET is busy: four accepted, fifth stalls.
      hold_busy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      acc = 0;
      c5 = '0;
      r5 = '0;
      for (int i = 0; i < 5; i++) begin
         c5 = rnd_central();
         r5 = 4'($urandom_range(0, 15));
         req_valid = 1'b1;
         req_central = c5;
         req_radius = r5;
         if (i == 4)
            check("full_ready", {31'd0, req_ready}, 0);
         if (req_ready) begin
            acc++;
            job_q.push_back('{c5, r5, tag_model});
            tag_model = (tag_model + 1) % TAG_MOD;
         end
         @(posedge clk);
         #1;
      end
      check("accepted", acc, 4);
      hold_busy = 1'b0;
      push_job(c5, r5);
      wait_drain(400);

      // Backpressure: result held for 20 cycles, nothing issues.
      rdy_mode = 2;
      push_job(rnd_central(), 4'($urandom_range(0, 15)));
      n = 0;
      while (!res_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("hold_seen", {31'd0, res_valid}, 1);
      push_job(rnd_central(), 4'($urandom_range(0, 15)));
      repeat (20) @(posedge clk);
      #1;
      check("hold_still_valid", {31'd0, res_valid}, 1);
      rdy_mode = 0;
      wait_drain(400);

      // Long random stream: tags wrap past 2^TAG_W.
      for (int i = 0; i < 70; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
         end
         push_job(rnd_central(), 4'($urandom_range(0, 15)));
      end
      wait_drain(3000);
      check("tag_wrapped", {31'd0, (tag_model < 70)}, 1);

      // Reset in WAIT with two jobs queued; late set_valid ignored.
      fix_lat = 40;
      for (int i = 0; i < 3; i++)
         push_job(rnd_central(), 4'($urandom_range(0, 15)));
      n = 0;
      while (job_q.size() != 2 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("two_queued", job_q.size(), 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      job_q.delete();
      exp_q.delete();
      tag_model = 0;
      check_reset_outputs();
      rst = 1'b0;
      base = res_seen;
      repeat (50) @(posedge clk);
      #1;
      check("late_valid_ignored", res_seen - base, 0);
      check("idle_after_drop", {31'd0, idle}, 1);
      fix_lat = -1;
      push_job(rnd_central(), 4'($urandom_range(0, 15)));
      wait_drain(200);

`ifdef SET_TIMEOUT_EN
      // Engine never answers: 8'hFF after TO_CYC WAIT cycles.
      check("to_err_clear", {31'd0, timeout_err}, 0);
      no_resp = 1'b1;
      push_job(rnd_central(), 4'($urandom_range(0, 15)));
      n = 0;
      while (!set_en && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      en_cyc = cyc;
      n = 0;
      while (!res_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("to_wait_cycles", cyc - en_cyc, TO_CYC);
      check("to_cand", res_candidate, 8'hFF);
      check("to_err_set", {31'd0, timeout_err}, 1);
      wait_drain(200);
      no_resp = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("to_err_sticky", {31'd0, timeout_err}, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      job_q.delete();
      exp_q.delete();
      tag_model = 0;
      check("to_err_rst", {31'd0, timeout_err}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
`endif

      check("job_q_empty", job_q.size(), 0);
      check("exp_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
